// File: rtl/load_seq_pkg.sv
// Purpose: shared types and reset constants for the reload-value sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: seq_state_t FSM encoding, reset values for the state and data_load registers.
package load_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
    } seq_state_t;

    localparam seq_state_t STATE_RST         = S_IDLE;
    // data_load resets to all-zeros; replicated to WIDTH at the use site.
    localparam logic       DATA_LOAD_RST_BIT = 1'b0;

endpackage

// File: rtl/load_sequencer_sync_fifo.sv
// Purpose: small synchronous FIFO buffering reload values ahead of the sequencer FSM.
// Latency: a push is visible on head/level one cycle later; no write-to-read bypass.
// Backpressure: full is derived from registered pointers only, so a same-cycle pop never frees a slot.
//
// Ports: clk, rst (sync, active-high); push/push_dat write side; pop/head_dat read side;
//        full, empty, level status (level is $clog2(DEPTH)+1 bits).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty,
    // equal addresses with differing wrap bits mean full.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: resetting the pointers flushes the contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/load_sequencer.sv
// Purpose: feeds buffered reload values to a loadable up-counter whenever cnt hits the terminal value.
// Latency: terminal hit sampled at edge N -> load/data_load registered from edge N to N+1.
// Backpressure: in_ready = FIFO not-full, from start-of-cycle occupancy only; no bypass when full.
//
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready reload input; enable, terminal, cnt
//        control and counter feedback; data_load/load to the counter; level, underrun status.
// Build option: define LOAD_SEQ_UNDERRUN_EN to flag (sticky) a terminal hit with an empty FIFO
//        and drop to IDLE; otherwise such a hit is ignored and underrun is tied low.
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         terminal,
    input  logic [WIDTH-1:0]         cnt,
    output logic [WIDTH-1:0]         data_load,
    output logic                     load,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);

    seq_state_t       state_q, state_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_load_q, data_load_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic             term_hit;

`ifdef LOAD_SEQ_UNDERRUN_EN
    logic             underrun_q, underrun_d;
`endif

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_dat (in_data),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign in_ready  = !fifo_full;
    assign term_hit  = (cnt == terminal);
    assign load      = load_q;
    assign data_load = data_load_q;

`ifdef LOAD_SEQ_UNDERRUN_EN
    assign underrun  = underrun_q;
`else
    assign underrun  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        load_d      = 1'b0;
        data_load_d = data_load_q;   // held between loads
        fifo_pop    = 1'b0;
`ifdef LOAD_SEQ_UNDERRUN_EN
        underrun_d  = underrun_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (term_hit) begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        data_load_d = fifo_head;
                        load_d      = 1'b1;
                        state_d     = S_LOAD;
                    end else begin
`ifdef LOAD_SEQ_UNDERRUN_EN
                        underrun_d  = 1'b1;
                        state_d     = S_IDLE;
`endif
                    end
                end
            end
            S_LOAD: begin
                // The pulse is already on the output; hits seen here are
                // ignored so loads are always separated by a WAIT cycle.
                state_d = enable ? S_WAIT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_RST;
            load_q      <= 1'b0;
            data_load_q <= {WIDTH{DATA_LOAD_RST_BIT}};
`ifdef LOAD_SEQ_UNDERRUN_EN
            underrun_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            data_load_q <= data_load_d;
`ifdef LOAD_SEQ_UNDERRUN_EN
            underrun_q  <= underrun_d;
`endif
        end
    end

endmodule
